bcd_to_bin_seq: RTL

- Sequential BCD-to-binary converter: the inverse of the score BCD path.
- Takes three BCD digits (hundreds, tens, ones), e.g. from the score-entry or stored high-score logic.
- Produces the binary value by reverse double-dabble, one shift per clock, with a start/busy/done handshake.
- Sits between BCD-domain game logic and binary consumers (score comparators, the point display input).

---
 rtl/bcd_to_bin_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential three-digit BCD to binary converter using reverse double-dabble, one shift per clock.
// Optional macro BCD_TO_BIN_SATURATE_EN: on overflow, clamp number to all ones instead of truncating.
module bcd_to_bin_seq #(
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] number,
  output logic             overflow,
  output logic             invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [10:0] LIMIT = 11'(2 ** BIN_W);

  state_t      state, state_nxt;
  logic [21:0] sreg;
  logic [21:0] sreg_step;
  logic [3:0]  cnt;
  logic        digit_bad;
  logic        load;
  logic        last;
  logic [9:0]  bin10;
  logic        res_ovf;

  // One reverse double-dabble iteration: shift right, then pull each BCD nibble back by 3 if >= 8.
  function automatic logic [21:0] dabble_step(input logic [21:0] r);
    logic [21:0] s;
    s = r >> 1;
    for (int i = 0; i < 3; i++) begin
      if (s[10 + 4*i +: 4] >= 4'd8)
        s[10 + 4*i +: 4] = s[10 + 4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

  function automatic logic [BIN_W-1:0] fit_result(input logic [9:0] v, input logic ovf);
`ifdef BCD_TO_BIN_SATURATE_EN
    if (ovf)
      return {BIN_W{1'b1}};
    return v[BIN_W-1:0];
`else
    if (ovf) begin
    end
    return v[BIN_W-1:0];
`endif
  endfunction

  assign sreg_step = dabble_step(sreg);
  assign bin10     = sreg_step[9:0];
  assign res_ovf   = ({1'b0, bin10} >= LIMIT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 4'd9) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      digit_bad <= 1'b0;
      number    <= '0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sreg      <= {hundreds, tens, ones, 10'b0};
        digit_bad <= (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
        cnt       <= '0;
      end else if (state == SHIFT) begin
        sreg <= sreg_step;
        cnt  <= cnt + 4'd1;
      end
      // Results only move on the final shift so they stay stable through the next conversion.
      if (last) begin
        invalid  <= digit_bad;
        overflow <= digit_bad ? 1'b0 : res_ovf;
        number   <= digit_bad ? '0 : fit_result(bin10, res_ovf);
      end
    end
  end

endmodule
